// File: rtl/column_amp_n_if.sv
// Column handshake and result bundle for column_amp_n.
// master = column source / result consumer, slave = the modulus unit.
interface column_amp_n_if #(
  parameter int COL_N  = 2,
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(COL_N);
  localparam int ACC_W = 2*DATA_W + CNT_W;
  localparam int OUT_W = (ACC_W + 1) / 2;

  logic                    I_col_valid;
  logic                    O_col_ready;
  logic [COL_N*DATA_W-1:0] I_column;
  logic [OUT_W-1:0]        O_amp;
  logic                    O_amp_valid;
  logic                    O_busy;

  modport master (
    output I_col_valid, I_column,
    input  O_col_ready, O_amp, O_amp_valid, O_busy
  );

  modport slave (
    input  I_col_valid, I_column,
    output O_col_ready, O_amp, O_amp_valid, O_busy
  );
endinterface

// File: rtl/column_amp_n.sv
// Euclidean modulus of one COL_N-element signed column: serial square accumulate, then
// bit-serial restoring sqrt. Define COLUMN_AMP_ROUND_EN to round to nearest instead of floor.
module column_amp_n #(
  parameter int COL_N  = 2,
  parameter int DATA_W = 16
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rstn,
  column_amp_n_if.slave col_if
);
  localparam int CNT_W = $clog2(COL_N);
  localparam int ACC_W = 2*DATA_W + CNT_W;
  localparam int OUT_W = (ACC_W + 1) / 2;
  localparam int SQ_W  = 2*OUT_W;
  localparam int REM_W = OUT_W + 2;
  localparam int STP_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_N - 1);
  localparam logic [STP_W-1:0] STP_LAST = STP_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SQRT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COL_N*DATA_W-1:0] col_q, col_d;
  logic [SQ_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [STP_W-1:0]        step_q, step_d;
  logic [OUT_W-1:0]        root_q, root_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic [OUT_W-1:0]        amp_q, amp_d;

  logic [DATA_W-1:0]   elem;
  logic [DATA_W-1:0]   mag;
  logic [2*DATA_W-1:0] sq;
  logic [REM_W+1:0]    rem_sh;
  logic [REM_W+1:0]    trial;
  logic                take;
  logic [REM_W-1:0]    rem_nxt;
  logic [OUT_W-1:0]    root_nxt;
  logic [OUT_W-1:0]    result;

  // Column register shifts down one element per ACCUM cycle; element 0 first.
  assign elem = col_q[DATA_W-1:0];
  assign mag  = elem[DATA_W-1] ? (DATA_W'(0) - elem) : elem;
  assign sq   = {{DATA_W{1'b0}}, mag} * {{DATA_W{1'b0}}, mag};

  // One restoring-sqrt step: bring down the next two acc bits, try root*4+1.
  assign rem_sh   = {rem_q, acc_q[SQ_W-1 -: 2]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign take     = (rem_sh >= trial);
  assign rem_nxt  = take ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
  assign root_nxt = {root_q[OUT_W-2:0], take};

`ifdef COLUMN_AMP_ROUND_EN
  // rem > root  <=>  acc >= (root + 1/2)^2 for integer acc.
  assign result = (rem_nxt > {2'b00, root_nxt}) ? (root_nxt + OUT_W'(1)) : root_nxt;
`else
  assign result = root_nxt;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    root_d  = root_q;
    rem_d   = rem_q;
    amp_d   = amp_q;
    unique case (state_q)
      IDLE: begin
        if (col_if.I_col_valid) begin
          col_d   = col_if.I_column;
          acc_d   = '0;
          cnt_d   = '0;
          step_d  = '0;
          root_d  = '0;
          rem_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + SQ_W'(sq);
        col_d = col_q >> DATA_W;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = SQRT;
        end
      end
      SQRT: begin
        acc_d  = acc_q << 2;
        rem_d  = rem_nxt;
        root_d = root_nxt;
        step_d = step_q + 1'b1;
        if (step_q == STP_LAST) begin
          amp_d   = result;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state_q <= IDLE;
      col_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      amp_q   <= amp_d;
    end
  end

  // Status decodes straight from state so an asynchronous reset shows at once.
  assign col_if.O_col_ready = (state_q == IDLE);
  assign col_if.O_busy      = (state_q != IDLE);
  assign col_if.O_amp_valid = (state_q == DONE);
  assign col_if.O_amp       = amp_q;

endmodule

// File: tb/tb_column_amp_n.sv
// Bench for column_amp_n: a COL_N=2 and a COL_N=4 instance checked against an
// integer-sqrt reference model with directed and random columns.
module tb_column_amp_n;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  column_amp_n_if #(.COL_N(2), .DATA_W(16)) if2 ();
  column_amp_n_if #(.COL_N(4), .DATA_W(16)) if4 ();

  column_amp_n #(.COL_N(2), .DATA_W(16)) dut2 (
    .I_sys_clk (clk),
    .I_sys_rstn(rstn),
    .col_if    (if2)
  );

  column_amp_n #(.COL_N(4), .DATA_W(16)) dut4 (
    .I_sys_clk (clk),
    .I_sys_rstn(rstn),
    .col_if    (if4)
  );

  // Reference: square sum, then integer sqrt by bitwise search, optional rounding.
  function automatic longint model_amp(input longint s);
    longint r;
    longint t;
    r = 0;
    for (int b = 20; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= s) r = t;
    end
`ifdef COLUMN_AMP_ROUND_EN
    if (s - r * r > r) r = r + 1;
`endif
    return r;
  endfunction

  function automatic longint sqr16(input logic [15:0] x);
    longint v;
    v = longint'($signed(x));
    return v * v;
  endfunction

  function automatic logic [31:0] pack2(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Drives one column into the 2-element unit. lat counts edges with the accept edge as 1.
  task automatic send2(input logic [31:0] col, output int lat, output logic [16:0] amp,
                       output bit hs_ok);
    lat = -1; amp = '0; hs_ok = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 50 && if2.O_col_ready !== 1'b1; w++) @(negedge clk);
    if2.I_column = col;
    if2.I_col_valid = 1'b1;
    @(posedge clk); #1;
    if2.I_col_valid = 1'b0;
    for (int n = 2; n <= 100; n++) begin
      if (if2.O_col_ready !== 1'b0 || if2.O_busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
      if (if2.O_amp_valid === 1'b1) begin
        lat = n; amp = if2.O_amp;
        if (if2.O_col_ready !== 1'b0 || if2.O_busy !== 1'b1) hs_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic send4(input logic [63:0] col, output int lat, output logic [16:0] amp);
    lat = -1; amp = '0;
    @(negedge clk);
    for (int w = 0; w < 50 && if4.O_col_ready !== 1'b1; w++) @(negedge clk);
    if4.I_column = col;
    if4.I_col_valid = 1'b1;
    @(posedge clk); #1;
    if4.I_col_valid = 1'b0;
    for (int n = 2; n <= 100; n++) begin
      @(posedge clk); #1;
      if (if4.O_amp_valid === 1'b1) begin
        lat = n; amp = if4.O_amp;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (if2.O_amp !== 17'd0) begin failures++; $display("FAIL rst_amp got=%0d exp=0", if2.O_amp); end
    checks++; if (if2.O_amp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if2.O_amp_valid); end
    checks++; if (if2.O_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", if2.O_busy); end
    checks++; if (if2.O_col_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", if2.O_col_ready); end
    checks++; if (if4.O_col_ready !== 1'b1 || if4.O_amp !== 17'd0) begin
      failures++; $display("FAIL rst4 ready=%b amp=%0d exp ready=1 amp=0", if4.O_col_ready, if4.O_amp);
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed2;
    int lat; logic [16:0] amp; bit hs;
    int exp_min;
    send2(pack2(3, 4), lat, amp, hs);
    checks++; if (amp !== 17'd5) begin failures++; $display("FAIL d2_3_4 got=%0d exp=5", amp); end
    checks++; if (lat != 20) begin failures++; $display("FAIL d2_latency got=%0d exp=20", lat); end
    checks++; if (!hs) begin failures++; $display("FAIL d2_ready_busy got=bad exp=ready0_busy1"); end
`ifdef COLUMN_AMP_ROUND_EN
    exp_min = 46341;
`else
    exp_min = 46340;
`endif
    send2(pack2(-32768, -32768), lat, amp, hs);
    checks++; if (amp !== 17'(exp_min)) begin failures++; $display("FAIL d2_min_min got=%0d exp=%0d", amp, exp_min); end
    send2(pack2(32767, -1), lat, amp, hs);
    checks++; if (amp !== 17'd32767) begin failures++; $display("FAIL d2_max_m1 got=%0d exp=32767", amp); end
  endtask

  task automatic test_zero_ignore;
    int strobes = 0; logic [16:0] amp_seen = 17'h1ffff;
    @(negedge clk);
    for (int w = 0; w < 50 && if2.O_col_ready !== 1'b1; w++) @(negedge clk);
    if2.I_column = '0; if2.I_col_valid = 1'b1;
    @(posedge clk); #1; if2.I_col_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    if2.I_column = pack2(6, 8); if2.I_col_valid = 1'b1;
    @(posedge clk); #1; if2.I_col_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (if2.O_amp_valid === 1'b1) begin strobes++; amp_seen = if2.O_amp; end
    end
    checks++; if (amp_seen !== 17'd0) begin failures++; $display("FAIL zero_amp got=%0d exp=0", amp_seen); end
    checks++; if (strobes != 1) begin failures++; $display("FAIL ignore_strobes got=%0d exp=1", strobes); end
    checks++; if (if2.O_amp !== 17'd0) begin failures++; $display("FAIL ignore_hold got=%0d exp=0", if2.O_amp); end
  endtask

  task automatic test_back_to_back;
    int cyc = 0, t1 = -1, t2 = -1;
    bit hold_bad = 1'b0, dropped = 1'b0, idle_seen = 1'b0;
    logic [16:0] a1 = '0, a2 = '0;
    @(negedge clk);
    for (int w = 0; w < 50 && if2.O_col_ready !== 1'b1; w++) @(negedge clk);
    if2.I_column = pack2(5, 12); if2.I_col_valid = 1'b1;
    for (int n = 0; n < 120 && t2 < 0; n++) begin
      @(posedge clk); #1; cyc++;
      if (idle_seen && !dropped) begin if2.I_col_valid = 1'b0; dropped = 1'b1; end
      if (if2.O_amp_valid === 1'b1) begin
        if (t1 < 0) begin t1 = cyc; a1 = if2.O_amp; if2.I_column = pack2(8, 15); end
        else begin t2 = cyc; a2 = if2.O_amp; end
      end else if (t1 >= 0 && if2.O_amp !== 17'd13) hold_bad = 1'b1;
      if (t1 >= 0 && if2.O_col_ready === 1'b1) idle_seen = 1'b1;
    end
    if2.I_col_valid = 1'b0;
    checks++; if (a1 !== 17'd13) begin failures++; $display("FAIL b2b_first got=%0d exp=13", a1); end
    checks++; if (a2 !== 17'd17) begin failures++; $display("FAIL b2b_second got=%0d exp=17", a2); end
    checks++; if (t2 - t1 != 21 || t1 < 0) begin failures++; $display("FAIL b2b_spacing got=%0d exp=21", t2 - t1); end
    checks++; if (hold_bad) begin failures++; $display("FAIL b2b_hold got=changed exp=13"); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [16:0] amp; bit hs; int strobes = 0;
    @(negedge clk);
    for (int w = 0; w < 50 && if2.O_col_ready !== 1'b1; w++) @(negedge clk);
    if2.I_column = pack2(3, 4); if2.I_col_valid = 1'b1;
    @(posedge clk); #1; if2.I_col_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    checks++; if (if2.O_amp !== 17'd0) begin failures++; $display("FAIL mid_rst_amp got=%0d exp=0", if2.O_amp); end
    checks++; if (if2.O_amp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", if2.O_amp_valid); end
    checks++; if (if2.O_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", if2.O_busy); end
    checks++; if (if2.O_col_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", if2.O_col_ready); end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (if2.O_amp_valid === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin failures++; $display("FAIL mid_rst_no_strobe got=%0d exp=0", strobes); end
    send2(pack2(3, 4), lat, amp, hs);
    checks++; if (amp !== 17'd5) begin failures++; $display("FAIL mid_rst_after got=%0d exp=5", amp); end
  endtask

  task automatic test_random2;
    int lat; logic [16:0] amp; bit hs;
    logic [15:0] e0, e1; longint exp_v;
    for (int i = 0; i < 25; i++) begin
      e0 = 16'($urandom); e1 = 16'($urandom);
      if (i == 0) e0 = 16'h8000;
      exp_v = model_amp(sqr16(e0) + sqr16(e1));
      send2({e1, e0}, lat, amp, hs);
      checks++;
      if (amp !== 17'(exp_v) || lat != 20) begin
        failures++;
        $display("FAIL rand2 col=(%0d,%0d) got=%0d/lat%0d exp=%0d/lat20", $signed(e0), $signed(e1), amp, lat, exp_v);
      end
    end
  endtask

  task automatic test_col4;
    int lat; logic [16:0] amp;
    logic [15:0] e [4]; longint s;
    send4(pack4(1, 2, 2, 4), lat, amp);
    checks++; if (amp !== 17'd5) begin failures++; $display("FAIL c4_1224 got=%0d exp=5", amp); end
    checks++; if (lat != 22) begin failures++; $display("FAIL c4_latency got=%0d exp=22", lat); end
    send4(pack4(1, 1, 1, 1), lat, amp);
    checks++; if (amp !== 17'd2) begin failures++; $display("FAIL c4_1111 got=%0d exp=2", amp); end
    send4(pack4(-32768, -32768, -32768, -32768), lat, amp);
    checks++; if (amp !== 17'd65536) begin failures++; $display("FAIL c4_min got=%0d exp=65536", amp); end
    for (int i = 0; i < 10; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin e[k] = 16'($urandom); s += sqr16(e[k]); end
      send4({e[3], e[2], e[1], e[0]}, lat, amp);
      checks++;
      if (amp !== 17'(model_amp(s)) || lat != 22) begin
        failures++;
        $display("FAIL rand4 sum=%0d got=%0d/lat%0d exp=%0d/lat22", s, amp, lat, model_amp(s));
      end
    end
  endtask

  initial begin
    if2.I_col_valid = 1'b0; if2.I_column = '0;
    if4.I_col_valid = 1'b0; if4.I_column = '0;
    test_reset();
    test_directed2();
    test_zero_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random2();
    test_col4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/column_amp_n.md
Name: column_amp_n

Overview:
- Parametrised successor to the 2-element column modulus unit in the matrix-inverse datapath.
- Computes the Euclidean modulus sqrt(sum a_i^2) of one COL_N-element signed column.
- Squares are accumulated serially, one element per clock; the square root is computed by a bit-serial restoring algorithm.
- Feeds the Givens/normalisation stage; adds a valid/ready input handshake, busy status and back-to-back column operation.

Parameters:
- COL_N, 2, number of elements per column (>=2).
- DATA_W, 16, element width, two's complement signed.
- Derived (localparam, not overridable):
  - CNT_W = clog2(COL_N)
  - ACC_W = 2*DATA_W + CNT_W
  - OUT_W = (ACC_W+1)/2 (COL_N=2, DATA_W=16 gives OUT_W=17)

Ports:
- I_sys_clk  in  1  system clock, rising edge.
- I_sys_rstn  in  1  asynchronous active-low reset.
- I_col_valid  in  1  column present on I_column.
- O_col_ready  out  1  block can accept a column.
- I_column  in  COL_N*DATA_W  packed column; element i at bits [i*DATA_W +: DATA_W], element 0 = row 1.
- O_amp  out  OUT_W  unsigned column modulus, held until the next result.
- O_amp_valid  out  1  one-cycle result strobe.
- O_busy  out  1  high in every state except IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low on I_sys_rstn; all state uses I_sys_clk rising edge.
- Reset values: O_amp=0, O_amp_valid=0, O_busy=0, O_col_ready=1, state=IDLE, all internal registers 0.
- FSM states: IDLE, ACCUM, SQRT, DONE.
- IDLE:
  - O_col_ready=1.
  - On I_col_valid=1 at a rising edge, I_column is latched into a local column register. Clear acc and the element counter cnt, then go to ACCUM.
  - I_column is not sampled again until the next IDLE acceptance.
- ACCUM:
  - Each cycle, acc += |e_cnt|^2 (unsigned, ACC_W bits) and cnt increments.
  - |x| for x = -2^(DATA_W-1) is 2^(DATA_W-1), held in DATA_W unsigned bits, with no overflow.
  - After COL_N cycles (cnt = COL_N-1 processed), go to SQRT. No accumulator overflow is possible by construction of ACC_W.
- SQRT:
  - Restoring square root with root register and remainder register (OUT_W+2 bits).
  - Consumes 2 acc bits per cycle from the MSB (acc zero-extended to 2*OUT_W).
  - Exactly OUT_W cycles, then go to DONE.
  - Result is floor(sqrt(acc)).
- DONE:
  - O_amp is registered with the result and O_amp_valid=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- O_col_ready is 0 in ACCUM, SQRT and DONE. I_col_valid in those states is ignored; the source holds the column until ready.
- Latency: accept edge to O_amp_valid high = COL_N + OUT_W + 1 edges; 20 for defaults.
- Throughput: one column per COL_N + OUT_W + 2 cycles.
- Back-to-back operation:
  - I_col_valid held high gives a second acceptance on the first IDLE cycle after DONE.
  - The previous O_amp stays stable until the next DONE.
- All-zero column gives O_amp=0 with normal latency and strobe.
- Reset mid-operation (any state) returns immediately to reset values. The in-flight column is discarded and no O_amp_valid is issued.

Optional Feature:
- Macro COLUMN_AMP_ROUND_EN.
- Defined: in DONE, O_amp = root+1 when remainder > root (round to nearest; exact halves are impossible for integer acc).
  - No overflow: max modulus sqrt(COL_N)*2^(DATA_W-1) < 2^OUT_W.
  - Latency unchanged.
- Undefined: O_amp = floor(sqrt(acc)); the rounding compare logic is absent.

Test Plan:
- Defaults, column (3,4) → O_amp=5, O_amp_valid high exactly 20 edges after the accept edge; O_col_ready=0 and O_busy=1 throughout.
- Defaults, column (-32768,-32768) → O_amp=46340; with COLUMN_AMP_ROUND_EN, 46341. Column (32767,-1) → 32767.
- Defaults, column (0,0) → O_amp=0 with valid strobe. Then I_col_valid pulsed during SQRT with (6,8) → ignored; O_amp remains 0 and no second strobe.
- Defaults, I_col_valid held high with (5,12) then (8,15) → strobes give 13 then 17, spaced 21 cycles apart; O_amp stays 13 between strobes.
- Reset: assert I_sys_rstn=0 asynchronously mid-SQRT → O_amp=0, O_amp_valid=0, O_busy=0, O_col_ready=1 immediately, before the next clock edge. Release, send (3,4) → 5.
- COL_N=4, DATA_W=16 (OUT_W=17):
  - (1,2,2,4) → 5 after 22 edges.
  - (1,1,1,1) → 2.
  - (-32768 x4) → 65536.
